// File: rtl/detect_faces_arith_pkg.sv
// Shared arithmetic definitions for the detectFaces multiply/accumulate datapath.
package detect_faces_arith_pkg;

   localparam int MAX_NUM_STAGE = 4;

   // Per-beat control tags that travel alongside the product through the pipe.
   typedef struct packed {
      logic valid;
      logic acc_en;
      logic acc_first;
      logic acc_last;
      logic is_signed;
   } beat_tag_t;

   // Width of the untruncated product of two operands, each widened by one bit.
   function automatic int full_prod_width(input int w0, input int w1);
      return w0 + w1 + 2;
   endfunction

endpackage

// File: rtl/detect_faces_mul_acc_pipe_if.sv
// Beat bus for the multiply/accumulate pipe.
// Handshake: a beat is taken on every clk edge where ce=1 and in_valid=1. There
// is no ready signal because the pipe always accepts one beat per ce-cycle.
// dout_valid and acc_valid are one-ce-cycle pulses, so consumers qualify them with ce.
interface detect_faces_mul_acc_pipe_if #(
   parameter int DIN0_WIDTH = 32,
   parameter int DIN1_WIDTH = 32,
   parameter int DOUT_WIDTH = 64
);
   logic                  in_valid;
   logic [DIN0_WIDTH-1:0] din0;
   logic [DIN1_WIDTH-1:0] din1;
   logic                  din0_signed;
   logic                  din1_signed;
   logic                  acc_en;
   logic                  acc_first;
   logic                  acc_last;
   logic [DOUT_WIDTH-1:0] dout;
   logic                  dout_valid;
   logic [DOUT_WIDTH-1:0] acc_out;
   logic                  acc_valid;
   logic                  acc_ovf;

   modport master (
      output in_valid, din0, din1, din0_signed, din1_signed, acc_en, acc_first, acc_last,
      input  dout, dout_valid, acc_out, acc_valid, acc_ovf
   );

   modport slave (
      input  in_valid, din0, din1, din0_signed, din1_signed, acc_en, acc_first, acc_last,
      output dout, dout_valid, acc_out, acc_valid, acc_ovf
   );
endinterface

// File: rtl/detect_faces_mul_core.sv
// Operand extension, signed multiply and the NUM_STAGE register chain carrying
// the truncated product together with its beat tags.
module detect_faces_mul_core
   import detect_faces_arith_pkg::*;
#(
   parameter int DIN0_WIDTH = 32,
   parameter int DIN1_WIDTH = 32,
   parameter int DOUT_WIDTH = 64,
   parameter int NUM_STAGE  = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ce,
   input  logic                  in_valid,
   input  logic [DIN0_WIDTH-1:0] din0,
   input  logic [DIN1_WIDTH-1:0] din1,
   input  logic                  din0_signed,
   input  logic                  din1_signed,
   input  logic                  acc_en,
   input  logic                  acc_first,
   input  logic                  acc_last,
   output logic [DOUT_WIDTH-1:0] out_data,
   output beat_tag_t             out_tag
);

   localparam int FULL_W = full_prod_width(DIN0_WIDTH, DIN1_WIDTH);

   logic signed [DIN0_WIDTH:0] a_ext;
   logic signed [DIN1_WIDTH:0] b_ext;
   logic signed [FULL_W-1:0]   a_full;
   logic signed [FULL_W-1:0]   b_full;
   logic signed [FULL_W-1:0]   full_prod;
   beat_tag_t                  tag_in;

   logic [DOUT_WIDTH-1:0] data_q [NUM_STAGE];
   beat_tag_t             tag_q  [NUM_STAGE];

   // One extra bit per operand lets a single signed multiplier cover every
   // signed/unsigned combination: unsigned operands get a zero top bit.
   assign a_ext     = {din0_signed & din0[DIN0_WIDTH-1], din0};
   assign b_ext     = {din1_signed & din1[DIN1_WIDTH-1], din1};
   assign a_full    = FULL_W'(a_ext);
   assign b_full    = FULL_W'(b_ext);
   assign full_prod = a_full * b_full;

   // Control inputs only count on a real beat, so bubbles carry all-zero tags.
   assign tag_in.valid     = in_valid;
   assign tag_in.acc_en    = in_valid & acc_en;
   assign tag_in.acc_first = in_valid & acc_en & acc_first;
   assign tag_in.acc_last  = in_valid & acc_en & acc_last;
   assign tag_in.is_signed = in_valid & (din0_signed | din1_signed);

   // Shift product and tags one stage per enabled cycle; reset empties the pipe.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_STAGE; i++) begin
            data_q[i] <= '0;
            tag_q[i]  <= '0;
         end
      end else if (ce) begin
         data_q[0] <= full_prod[DOUT_WIDTH-1:0];
         tag_q[0]  <= tag_in;
         for (int i = 1; i < NUM_STAGE; i++) begin
            data_q[i] <= data_q[i-1];
            tag_q[i]  <= tag_q[i-1];
         end
      end
   end

   assign out_data = data_q[NUM_STAGE-1];
   assign out_tag  = tag_q[NUM_STAGE-1];

endmodule

// File: rtl/detect_faces_mul_acc_pipe.sv
// Pipelined multiplier with optional accumulator for Haar-feature products and
// window sums. The last multiply stage drives dout; one more stage accumulates.
module detect_faces_mul_acc_pipe
   import detect_faces_arith_pkg::*;
#(
   parameter int DIN0_WIDTH = 32,
   parameter int DIN1_WIDTH = 32,
   parameter int DOUT_WIDTH = 64,
   parameter int NUM_STAGE  = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       ce,
   detect_faces_mul_acc_pipe_if.slave bus
);

   logic [DOUT_WIDTH-1:0] prod;
   beat_tag_t             ret;
   logic [DOUT_WIDTH-1:0] acc_q;
   logic                  acc_ovf_q;
   logic                  acc_valid_q;
   logic [DOUT_WIDTH-1:0] acc_base;
   logic [DOUT_WIDTH:0]   sum;
   logic                  signed_ovf;
   logic                  beat_ovf;

   detect_faces_mul_core #(
      .DIN0_WIDTH (DIN0_WIDTH),
      .DIN1_WIDTH (DIN1_WIDTH),
      .DOUT_WIDTH (DOUT_WIDTH),
      .NUM_STAGE  (NUM_STAGE)
   ) u_core (
      .clk         (clk),
      .reset       (reset),
      .ce          (ce),
      .in_valid    (bus.in_valid),
      .din0        (bus.din0),
      .din1        (bus.din1),
      .din0_signed (bus.din0_signed),
      .din1_signed (bus.din1_signed),
      .acc_en      (bus.acc_en),
      .acc_first   (bus.acc_first),
      .acc_last    (bus.acc_last),
      .out_data    (prod),
      .out_tag     (ret)
   );

   // Add the retiring product to the running sum (or to zero when starting a new
   // sum) and flag overflow in the beat's own signedness.
   always_comb begin
      acc_base   = ret.acc_first ? '0 : acc_q;
      sum        = {1'b0, acc_base} + {1'b0, prod};
      signed_ovf = (acc_base[DOUT_WIDTH-1] == prod[DOUT_WIDTH-1]) &&
                   (sum[DOUT_WIDTH-1] != prod[DOUT_WIDTH-1]);
      beat_ovf   = ret.is_signed ? signed_ovf : sum[DOUT_WIDTH];
   end

   // Accumulator stage: updates only for retiring acc_en beats; acc_valid pulses
   // on the beat that closes the sum and otherwise holds with ce low.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q       <= '0;
         acc_ovf_q   <= 1'b0;
         acc_valid_q <= 1'b0;
      end else if (ce) begin
         acc_valid_q <= ret.acc_en & ret.acc_last;
         if (ret.acc_en) begin
            acc_q     <= sum[DOUT_WIDTH-1:0];
            acc_ovf_q <= (ret.acc_first ? 1'b0 : acc_ovf_q) | beat_ovf;
         end
      end
   end

   assign bus.dout       = prod;
   assign bus.dout_valid = ret.valid;
   assign bus.acc_out    = acc_q;
   assign bus.acc_valid  = acc_valid_q;
   assign bus.acc_ovf    = acc_ovf_q;

endmodule

// File: doc/detect_faces_mul_acc_pipe.md
Name: detect_faces_mul_acc_pipe

Overview:
Parameterised, pipelined multiplier with an optional accumulator for the detectFaces datapath, used for Haar-feature weight × integral-image products and window sums. It generalises the fixed 1-stage unsigned multiplier in four ways: configurable stage count, per-operand runtime signedness, valid tracking through the pipe, and a multiply-accumulate output with overflow flag. All state advances only on ce.

Parameters:
DIN0_WIDTH, 32, operand 0 width (≥2)
DIN1_WIDTH, 32, operand 1 width (≥2)
DOUT_WIDTH, 64, product/accumulator width; the full product is truncated to its low DOUT_WIDTH bits
NUM_STAGE, 2, multiply pipeline depth in ce-cycles (1..4)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ce  in  1  clock enable; 0 freezes every register except under reset
in_valid  in  1  input beat present
din0  in  DIN0_WIDTH  operand 0
din1  in  DIN1_WIDTH  operand 1
din0_signed  in  1  1: din0 is two's complement; 0: unsigned
din1_signed  in  1  1: din1 is two's complement; 0: unsigned
acc_en  in  1  beat participates in accumulation
acc_first  in  1  beat starts a new accumulation (with acc_en)
acc_last  in  1  beat ends the accumulation (with acc_en)
dout  out  DOUT_WIDTH  product
dout_valid  out  1  dout holds a retired beat
acc_out  out  DOUT_WIDTH  accumulated sum
acc_valid  out  1  acc_out is final for a completed accumulation
acc_ovf  out  1  sticky overflow for the current or last accumulation

Behaviour:
- Clock is clk. Reset is synchronous and active-high on reset, and it overrides ce.
- Reset clears all pipeline valid bits, data registers, the accumulator, and every output to 0. In-flight beats are dropped and never produce dout_valid or acc_valid.
- Extension: each operand is extended by 1 bit, with the sign bit when its signed flag is 1 and with 0 otherwise. The extended operands are multiplied as signed values.
  - The full width is DIN0_WIDTH+DIN1_WIDTH+2 bits; the low DOUT_WIDTH bits are kept.
  - A beat's product is "signed" if either flag is 1.
- Pipeline: the beat, its valid bit, and its acc_en/acc_first/acc_last/signed tags advance one stage per ce=1 cycle.
  - dout and dout_valid are registered. They reflect a beat NUM_STAGE ce-cycles after capture.
  - With ce=0 all registers, including outputs and acc_valid, hold their values. Consumers qualify dout_valid and acc_valid with ce.
  - A bubble (in_valid=0) produces dout_valid=0. Control inputs are ignored when in_valid=0.
- Throughput: one beat per ce-cycle, with no back-pressure.
- Accumulator: one extra register stage after the multiply pipe. It acts on a retiring beat with acc_en=1:
  - If acc_first=1: acc = product, and acc_ovf is cleared and then re-evaluated for this beat (starts at 0).
  - If acc_first=0: acc = acc + product, wrapping modulo 2^DOUT_WIDTH.
  - Overflow:
    - For a signed beat, acc_ovf is set on two's-complement overflow of the add.
    - For an unsigned beat, acc_ovf is set on carry-out.
    - acc_ovf is sticky until the next acc_first.
  - If acc_last=1: acc_valid=1 in the same ce-cycle that acc_out presents the final sum. Latency is NUM_STAGE+1 ce-cycles from capture of the last beat.
  - acc_valid lasts one ce-cycle; otherwise it is 0.
  - acc_first and acc_last on the same beat give acc_out = product.
  - A beat with acc_first=0 and no prior first accumulates onto the held value (0 after reset).
  - Beats with acc_en=0 leave acc and acc_ovf untouched. acc_first/acc_last are ignored when acc_en=0.
- acc_out continuously shows the accumulator register; it is meaningful when acc_valid=1.

Decomposition:
- Shared package detect_faces_arith_pkg:
  - MAX_NUM_STAGE=4
  - beat tag struct (valid, acc_en, acc_first, acc_last, is_signed)
  - function returning the full product width
- Sub-module detect_faces_mul_core: operand extension, multiply, and the NUM_STAGE register chain carrying data and tags. The top level adds the output stage and accumulator.

Test Plan:
1. Unsigned full-scale product:
   - Stimulus: din0=din1=0xFFFFFFFF, both unsigned, in_valid=1, ce=1.
   - Response: 2 cycles later dout=0xFFFFFFFE00000001, with dout_valid high for exactly 1 cycle.
2. Signedness:
   - Stimulus: din0=0xFFFFFFFF signed, din1=5 signed. Then repeat with din0 unsigned.
   - Response: dout=0xFFFFFFFFFFFFFFFB for the signed case, then dout=0x00000004FFFFFFFB.
3. ce stall:
   - Stimulus: capture a beat, ce=0 for 3 cycles after 1 cycle, then ce=1.
   - Response: dout_valid rises only after the 2nd ce-high cycle. Outputs are frozen during the stall.
4. Accumulate:
   - Stimulus: unsigned beats 3×4 (first), 5×6, 7×8 (last), back-to-back.
   - Response: acc_out=98 and acc_valid=1 three cycles after the last beat, with acc_ovf=0. A bubble inserted mid-sequence gives the same result.
5. Overflow:
   - Stimulus: unsigned 0xFFFFFFFF×0xFFFFFFFF (first), then the same product (last).
   - Response: acc_out=0xFFFFFFFC00000002 and acc_ovf=1. A following single first+last beat 2×2 gives acc_out=4 and acc_ovf=0.
6. Reset mid-flight:
   - Stimulus: beat in stage 1, reset=1 for one cycle with ce=0.
   - Response: all outputs are 0 next cycle. No dout_valid or acc_valid ever appears for the dropped beat.
